match_datapath: RTL and testbench
=================================

# match_datapath

Datapath partner for the compare/replace control unit: it executes the load strobes issued by that FSM and returns the compare status that steers its branch. It captures an input word into A, flags whether A equals a configured key, builds B as either a replacement constant (match) or A (no match), and publishes B on an output register with a one-cycle valid pulse. A small phase tracker checks that the strobe sequence is legal, and a saturating counter records the number of matches.

## Interface
- WIDTH, 8: data width of din, A, B and dout.
- KEY, 8'h5A: compare value; A == KEY means a match.
- REPLACE, 8'hFF: value loaded into B on the match path.
- CNT_W, 8: width of match_count.
- clock  in  1  the only clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  input word, sampled when ALoad = 1.
- ALoad  in  1  load A from din.
- BLoad  in  1  load B through the mux.
- Muxsel  in  1  mux select: 1 loads REPLACE, 0 loads A.
- out_ctrl  in  1  transfer B to dout.
- Astatus  out  1  registered (din == KEY), captured with A.
- dout  out  WIDTH  output register.
- dout_valid  out  1  one-cycle pulse, high in the cycle after out_ctrl.
- match_count  out  CNT_W  saturating count of BLoad with Muxsel = 1.
- seq_err  out  1  sticky strobe-sequence error flag.

## Operation
- Reset (rst = 1 at an edge) clears A, B, dout, Astatus, dout_valid, match_count and seq_err, and sets the phase to P_WAIT_A. Reset overrides every strobe in the same cycle.
- ALoad: A <= din and Astatus <= (din == KEY). Otherwise both hold.
- BLoad: B <= Muxsel ? REPLACE : A, using A's pre-edge value. If Muxsel = 1, match_count increments and saturates at all-ones.
- out_ctrl: dout <= B (pre-edge value) and dout_valid <= 1. In every other cycle, dout_valid <= 0. dout holds between transfers.
- Phase tracker states: P_WAIT_A, P_HAVE_A, P_HAVE_B.
  - ALoad: any phase -> P_HAVE_A.
  - BLoad: P_HAVE_A -> P_HAVE_B.
  - out_ctrl: P_HAVE_B -> P_WAIT_A.
  - No strobe: phase holds.
- seq_err is set, and stays set until rst, on any of the following:
  - BLoad in P_WAIT_A or P_HAVE_B;
  - out_ctrl in P_WAIT_A or P_HAVE_A;
  - ALoad in P_HAVE_B (output skipped);
  - two or more of ALoad, BLoad or out_ctrl asserted in the same cycle;
  - Muxsel = 1 without BLoad.
- On any error the phase goes to P_WAIT_A. Data registers still execute every asserted strobe independently, so an error only sets the flag; it never blocks a load.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Astatus is valid in the cycle after ALoad, which is the controller's s_extra cycle, so it can be sampled at the end of s_extra.
- Legal sequence latency: ALoad in cycle n, idle in n+1, BLoad in n+2, out_ctrl in n+3, dout / dout_valid visible in n+4.
- Back-to-back frames need no gap: ALoad may be asserted in the cycle dout_valid is high.
- Reset mid-frame discards A, B and the phase. The next legal frame starts from P_WAIT_A with no error.

## Structure
- Shared header (match_pkg.vh) holds:
  - the controller state encodings (s_input = 0, s_extra = 1, s_notequal = 2, s_equal = 3, s_output = 4);
  - the phase encodings P_WAIT_A = 0, P_HAVE_A = 1, P_HAVE_B = 2;
  - the default KEY and REPLACE values.
- One sub-module, match_seq_checker, contains the phase FSM and seq_err. The registers, mux, comparator and counter stay in the top module.
- Top-level integration (not part of this block) instantiates the control unit together with match_datapath, wiring the strobes and Astatus between them.

## Test plan
- **Match frame.** Reset, then din = 0x5A with ALoad, then the full legal sequence with Muxsel = 1. Required: Astatus = 1 in cycle n+1; dout = 0xFF with dout_valid high in n+4 only; match_count = 1; seq_err = 0.
- **Non-match frame.** din = 0x3C, same sequence with Muxsel = 0. Required: Astatus = 0; dout = 0x3C; match_count unchanged.
- **Counter saturation.** CNT_W = 2; run 5 match frames. Required: match_count = 3 and holds; dout_valid pulses 5 times.
- **Sequence errors.** Drive BLoad straight after reset. Separately, drive ALoad and out_ctrl in the same cycle. Required: seq_err = 1 from the next cycle and sticky across a following legal frame. That legal frame still produces the correct dout.
- **Reset mid-frame.** Assert rst in cycle n+2 after a matching ALoad. Required: all outputs 0 in n+3; the next legal non-match frame produces dout = din with seq_err = 0.
- **Closed loop with the controller.** Run 10 random din values, 3 of them equal to 0x5A. Required: dout sequence matches the model, match_count = 3, seq_err = 0.

Source files
------------

// File: rtl/match_datapath_pkg.sv
// Shared definitions for the compare/replace datapath and its controller.
// Holds the controller state encodings, the strobe-phase encodings used by
// the sequence checker, and the default KEY / REPLACE values.
package match_datapath_pkg;

  typedef enum logic [2:0] {
    s_input    = 3'd0,
    s_extra    = 3'd1,
    s_notequal = 3'd2,
    s_equal    = 3'd3,
    s_output   = 3'd4
  } ctrl_state_t;

  typedef enum logic [1:0] {
    P_WAIT_A = 2'd0,
    P_HAVE_A = 2'd1,
    P_HAVE_B = 2'd2
  } phase_t;

  localparam logic [7:0] DEFAULT_KEY     = 8'h5A;
  localparam logic [7:0] DEFAULT_REPLACE = 8'hFF;

endpackage

// File: rtl/match_datapath_seq_checker.sv
// match_seq_checker: tracks the legal ALoad -> BLoad -> out_ctrl strobe
// order and raises a sticky error flag on any illegal strobe pattern.
//   clock    in   rising-edge clock
//   rst      in   synchronous active-high reset
//   ALoad    in   A load strobe
//   BLoad    in   B load strobe
//   Muxsel   in   mux select (only meaningful together with BLoad)
//   out_ctrl in   output transfer strobe
//   seq_err  out  sticky sequence error, cleared only by rst
module match_seq_checker
  import match_datapath_pkg::*;
(
  input  logic clock,
  input  logic rst,
  input  logic ALoad,
  input  logic BLoad,
  input  logic Muxsel,
  input  logic out_ctrl,
  output logic seq_err
);

  phase_t phase, phase_n;
  logic   err_now;
  logic   multi_strobe;

  assign multi_strobe = (2'(ALoad) + 2'(BLoad) + 2'(out_ctrl)) >= 2'd2;

  always_comb begin
    err_now = multi_strobe
            | (BLoad    & (phase != P_HAVE_A))
            | (out_ctrl & (phase != P_HAVE_B))
            | (ALoad    & (phase == P_HAVE_B))
            | (Muxsel   & ~BLoad);

    phase_n = phase;
    if (err_now)       phase_n = P_WAIT_A;
    else if (ALoad)    phase_n = P_HAVE_A;
    else if (BLoad)    phase_n = P_HAVE_B;
    else if (out_ctrl) phase_n = P_WAIT_A;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      phase   <= P_WAIT_A;
      seq_err <= 1'b0;
    end else begin
      phase <= phase_n;
      if (err_now) seq_err <= 1'b1;
    end
  end

endmodule

// File: rtl/match_datapath.sv
// match_datapath: executes the controller's load strobes. Captures din into
// A with a registered KEY-compare status, builds B from REPLACE (match) or
// A (no match), and publishes B on dout with a one-cycle valid pulse. Also
// counts match loads (saturating) and flags illegal strobe sequences.
//   clock       in   rising-edge clock
//   rst         in   synchronous active-high reset
//   din         in   input word, sampled on ALoad
//   ALoad       in   load A from din
//   BLoad       in   load B through the mux
//   Muxsel      in   1: B <= REPLACE, 0: B <= A
//   out_ctrl    in   transfer B to dout
//   Astatus     out  registered (din == KEY), captured with A
//   dout        out  output register
//   dout_valid  out  one-cycle pulse after out_ctrl
//   match_count out  saturating count of BLoad with Muxsel = 1
//   seq_err     out  sticky strobe-sequence error
module match_datapath
  import match_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] KEY = WIDTH'(DEFAULT_KEY),
  parameter logic [WIDTH-1:0] REPLACE = WIDTH'(DEFAULT_REPLACE),
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             ALoad,
  input  logic             BLoad,
  input  logic             Muxsel,
  input  logic             out_ctrl,
  output logic             Astatus,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CNT_W-1:0] match_count,
  output logic             seq_err
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  // Strobes act independently of the sequence checker: an illegal sequence
  // only raises seq_err, it never suppresses a load.
  always_ff @(posedge clock) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      dout        <= '0;
      Astatus     <= 1'b0;
      dout_valid  <= 1'b0;
      match_count <= '0;
    end else begin
      if (ALoad) begin
        a_reg   <= din;
        Astatus <= (din == KEY);
      end
      if (BLoad) begin
        b_reg <= Muxsel ? REPLACE : a_reg;
        if (Muxsel && (match_count != '1))
          match_count <= match_count + 1'b1;
      end
      if (out_ctrl) dout <= b_reg;
      dout_valid <= out_ctrl;
    end
  end

  match_seq_checker u_seq_checker (
    .clock    (clock),
    .rst      (rst),
    .ALoad    (ALoad),
    .BLoad    (BLoad),
    .Muxsel   (Muxsel),
    .out_ctrl (out_ctrl),
    .seq_err  (seq_err)
  );

endmodule

// File: tb/tb_match_datapath.sv
module tb_match_datapath;

  logic       clock = 1'b0;
  logic       rst, ALoad, BLoad, Muxsel, out_ctrl;
  logic [7:0] din;

  logic       Astatus, dout_valid, seq_err;
  logic [7:0] dout, match_count;
  logic       Astatus2, dout_valid2, seq_err2;
  logic [7:0] dout2;
  logic [1:0] match_count2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mA, mB, mdout;
  logic       mstat, mvalid, merr;
  int         mcnt, mcnt2;
  int         need;   // 0: expecting A load, 1: expecting B load, 2: expecting output

  always #5 clock = ~clock;

  match_datapath dut (
    .clock(clock), .rst(rst), .din(din), .ALoad(ALoad), .BLoad(BLoad),
    .Muxsel(Muxsel), .out_ctrl(out_ctrl), .Astatus(Astatus), .dout(dout),
    .dout_valid(dout_valid), .match_count(match_count), .seq_err(seq_err)
  );

  match_datapath #(.CNT_W(2)) dut2 (
    .clock(clock), .rst(rst), .din(din), .ALoad(ALoad), .BLoad(BLoad),
    .Muxsel(Muxsel), .out_ctrl(out_ctrl), .Astatus(Astatus2), .dout(dout2),
    .dout_valid(dout_valid2), .match_count(match_count2), .seq_err(seq_err2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, a, b, m, o, input logic [7:0] d);
    logic bad;
    if (r) begin
      mA = '0; mB = '0; mdout = '0; mstat = 0; mvalid = 0; merr = 0;
      mcnt = 0; mcnt2 = 0; need = 0;
    end else begin
      bad = (int'(a) + int'(b) + int'(o) > 1) || (b && need != 1) ||
            (o && need != 2) || (a && need == 2) || (m && !b);
      if (bad) merr = 1;
      if (bad) need = 0;
      else if (a) need = 1;
      else if (b) need = 2;
      else if (o) need = 0;
      mvalid = o;
      if (o) mdout = mB;
      if (b) begin
        mB = m ? 8'hFF : mA;
        if (m) begin
          mcnt  = (mcnt  < 255) ? mcnt + 1  : 255;
          mcnt2 = (mcnt2 < 3)   ? mcnt2 + 1 : 3;
        end
      end
      if (a) begin
        mA = d;
        mstat = (d == 8'h5A);
      end
    end
  endtask

  task automatic cyc(input logic r, a, b, m, o, input logic [7:0] d);
    rst = r; ALoad = a; BLoad = b; Muxsel = m; out_ctrl = o; din = d;
    @(posedge clock);
    model(r, a, b, m, o, d);
    #1;
    chk("astatus",     int'(Astatus),     int'(mstat));
    chk("dout",        int'(dout),        int'(mdout));
    chk("dout_valid",  int'(dout_valid),  int'(mvalid));
    chk("match_count", int'(match_count), mcnt);
    chk("seq_err",     int'(seq_err),     int'(merr));
    chk("dout_w2",     int'(dout2),       int'(mdout));
    chk("count_w2",    int'(match_count2), mcnt2);
    chk("astatus_w2",  int'(Astatus2),    int'(mstat));
    chk("valid_w2",    int'(dout_valid2), int'(mvalid));
    chk("seq_err_w2",  int'(seq_err2),    int'(merr));
  endtask

  task automatic frame(input logic [7:0] d, input logic m);
    cyc(0, 1, 0, 0, 0, d);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, m, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
  endtask

  initial begin
    int pulses;
    bit is_m[10];
    int placed;
    int j;
    logic [7:0] d;
    logic sel;

    rst = 1; ALoad = 0; BLoad = 0; Muxsel = 0; out_ctrl = 0; din = '0;
    #2;

    // Reset state
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("reset_dout", int'(dout), 0);
    chk("reset_seq_err", int'(seq_err), 0);

    // Match frame
    cyc(0, 1, 0, 0, 0, 8'h5A);
    chk("match_astatus_n1", int'(Astatus), 1);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 1, 0, 8'h00);
    chk("match_valid_early", int'(dout_valid), 0);
    cyc(0, 0, 0, 0, 1, 8'h00);
    chk("match_dout", int'(dout), 8'hFF);
    chk("match_valid", int'(dout_valid), 1);
    chk("match_count1", int'(match_count), 1);
    chk("match_seq_err", int'(seq_err), 0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("match_valid_drop", int'(dout_valid), 0);

    // Non-match frame
    cyc(0, 1, 0, 0, 0, 8'h3C);
    chk("nomatch_astatus", int'(Astatus), 0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00);
    chk("nomatch_dout", int'(dout), 8'h3C);
    chk("nomatch_count", int'(match_count), 1);

    // Counter saturation on the narrow instance, back-to-back frames
    cyc(1, 0, 0, 0, 0, 8'h00);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      frame(8'h5A, 1'b1);
      if (dout_valid2) pulses++;
    end
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("sat_count_w2", int'(match_count2), 3);
    chk("sat_count_w8", int'(match_count), 5);
    chk("sat_pulses", pulses, 5);

    // Sequence error: BLoad straight after reset, then a legal frame
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("err_bload_first", int'(seq_err), 1);
    frame(8'h21, 1'b0);
    chk("err_sticky_dout", int'(dout), 8'h21);
    chk("err_sticky_flag", int'(seq_err), 1);

    // Sequence error: ALoad with out_ctrl in one cycle
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 1, 8'h77);
    chk("err_multi_strobe", int'(seq_err), 1);
    frame(8'h5A, 1'b1);
    chk("err_multi_dout", int'(dout), 8'hFF);
    chk("err_multi_sticky", int'(seq_err), 1);

    // Muxsel without BLoad
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'h00);
    chk("err_muxsel_alone", int'(seq_err), 1);

    // Reset mid-frame
    cyc(1, 0, 0, 0, 0, 8'h00);
    frame(8'h11, 1'b0);
    cyc(0, 1, 0, 0, 0, 8'h5A);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("midrst_astatus", int'(Astatus), 0);
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_count", int'(match_count), 0);
    frame(8'h3C, 1'b0);
    chk("midrst_dout_after", int'(dout), 8'h3C);
    chk("midrst_seq_err", int'(seq_err), 0);

    // Closed loop: Muxsel follows the DUT's Astatus as the controller would
    cyc(1, 0, 0, 0, 0, 8'h00);
    placed = 0;
    while (placed < 3) begin
      j = $urandom_range(9);
      if (!is_m[j]) begin
        is_m[j] = 1'b1;
        placed++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (is_m[i]) d = 8'h5A;
      else begin
        d = 8'($urandom_range(255));
        while (d == 8'h5A) d = 8'($urandom_range(255));
      end
      cyc(0, 1, 0, 0, 0, d);
      sel = Astatus;
      cyc(0, 0, 0, 0, 0, 8'h00);
      cyc(0, 0, 1, sel, 0, 8'h00);
      cyc(0, 0, 0, 0, 1, 8'h00);
      chk("loop_dout", int'(dout), is_m[i] ? 8'hFF : int'(d));
    end
    chk("loop_count", int'(match_count), 3);
    chk("loop_seq_err", int'(seq_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
